// File: rtl/uart_msg_tx_seq.sv
// Streams one of MSG_COUNT table messages into a UART TX load port, pacing each byte on txempty.
// First load 1 cycle after start; 3 cycles/byte minimum; stalls in WAITSEND while txempty=0. Optional CR/LF tail: UART_MSG_CRLF_EN.
module uart_msg_tx_seq #(
    parameter int MSG_COUNT = 4,
    parameter int MAX_LEN   = 16,
    parameter int SEL_W     = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1,
    parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [SEL_W-1:0]               msg_sel,
    input  logic [MSG_COUNT*MAX_LEN*8-1:0] msg_bytes,
    input  logic [MSG_COUNT*LEN_W-1:0]     msg_len,
    input  logic                           txempty,
    output logic [7:0]                     txdata,
    output logic                           ldtxdata,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAITLOAD,
        WAITSEND,
`ifdef UART_MSG_CRLF_EN
        TAIL,
`endif
        FINISH,
        ERROR
    } state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_r, sel_n;
    logic [LEN_W-1:0]   len_r, len_n;
    logic [LEN_W-1:0]   idx_r, idx_n;
    logic [LEN_W-1:0]   len_raw, len_in;
    logic               sel_ok;
    logic [7:0]         msg_byte;
    logic [7:0]         txdata_n;
    logic               ld_n, busy_n, done_n, err_n;
`ifdef UART_MSG_CRLF_EN
    logic [1:0]         tail_r, tail_n;
    logic               in_tail_r, in_tail_n;
`endif

    // Length lookup for the requested message; out-of-range selects leave sel_ok low.
    always_comb begin
        len_raw = '0;
        sel_ok  = 1'b0;
        for (int i = 0; i < MSG_COUNT; i++) begin
            if (msg_sel == SEL_W'(i)) begin
                sel_ok  = 1'b1;
                len_raw = msg_len[i*LEN_W +: LEN_W];
            end
        end
        len_in = (len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_raw;
    end

    always_comb begin
        state_n = state;
        sel_n   = sel_r;
        len_n   = len_r;
        idx_n   = idx_r;
`ifdef UART_MSG_CRLF_EN
        tail_n    = tail_r;
        in_tail_n = in_tail_r;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    sel_n = msg_sel;
                    len_n = len_in;
                    idx_n = '0;
`ifdef UART_MSG_CRLF_EN
                    tail_n    = 2'd0;
                    in_tail_n = 1'b0;
`endif
                    if (!sel_ok)
                        state_n = ERROR;
                    else if (len_in == '0)
`ifdef UART_MSG_CRLF_EN
                        state_n = TAIL;
`else
                        state_n = FINISH;
`endif
                    else
                        state_n = LOAD;
                end
            end
            LOAD:     state_n = WAITLOAD;
            WAITLOAD: state_n = WAITSEND;
            WAITSEND: begin
                if (txempty) begin
`ifdef UART_MSG_CRLF_EN
                    if (in_tail_r) begin
                        tail_n  = tail_r + 2'd1;
                        state_n = TAIL;
                    end else begin
                        idx_n   = idx_r + LEN_W'(1);
                        state_n = (idx_r + LEN_W'(1) == len_r) ? TAIL : LOAD;
                    end
`else
                    idx_n   = idx_r + LEN_W'(1);
                    state_n = (idx_r + LEN_W'(1) == len_r) ? FINISH : LOAD;
`endif
                end
            end
`ifdef UART_MSG_CRLF_EN
            TAIL: begin
                if (tail_r == 2'd2) begin
                    state_n = FINISH;
                end else begin
                    in_tail_n = 1'b1;
                    state_n   = LOAD;
                end
            end
`endif
            FINISH:   state_n = IDLE;
            ERROR:    state_n = IDLE;
            default:  state_n = IDLE;
        endcase

        // Byte fetched live from the table using the next-cycle select/index.
        msg_byte = 8'h00;
        for (int i = 0; i < MSG_COUNT; i++) begin
            for (int j = 0; j < MAX_LEN; j++) begin
                if (sel_n == SEL_W'(i) && idx_n == LEN_W'(j))
                    msg_byte = msg_bytes[(i*MAX_LEN + j)*8 +: 8];
            end
        end

        ld_n   = (state_n == LOAD);
        busy_n = (state_n != IDLE);
        done_n = (state_n == FINISH);
        err_n  = (state_n == ERROR);
`ifdef UART_MSG_CRLF_EN
        txdata_n = !ld_n ? 8'h00 : in_tail_n ? ((tail_n == 2'd0) ? 8'h0D : 8'h0A) : msg_byte;
`else
        txdata_n = ld_n ? msg_byte : 8'h00;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel_r    <= '0;
            len_r    <= '0;
            idx_r    <= '0;
            txdata   <= 8'h00;
            ldtxdata <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef UART_MSG_CRLF_EN
            tail_r    <= 2'd0;
            in_tail_r <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            sel_r    <= sel_n;
            len_r    <= len_n;
            idx_r    <= idx_n;
            txdata   <= txdata_n;
            ldtxdata <= ld_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
`ifdef UART_MSG_CRLF_EN
            tail_r    <= tail_n;
            in_tail_r <= in_tail_n;
`endif
        end
    end

endmodule
